// File: rtl/coin_credit_unit.sv
// coin_credit_unit: accumulates coin credit against a price and dispenses change one coin at a time
module coin_credit_unit #(
  parameter int CREDIT_W = 10,
  parameter int MAX_CREDIT = 500
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic [CREDIT_W-1:0] price,
  input  logic                vend_done,
  input  logic                cancel,
  input  logic                change_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                credit_ok,
  output logic                coin_event,
  output logic                coin_reject,
  output logic                change_valid,
  output logic [1:0]          change_coin,
  output logic                change_short,
  output logic                busy
);
  typedef enum logic {ACCUM, CHANGE} state_t;
  localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] C5 = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] C10 = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] C25 = CREDIT_W'(25);
  localparam logic [CREDIT_W-1:0] C100 = CREDIT_W'(100);
  state_t state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d, coin_val, change_val;
  logic [CREDIT_W:0] sum;
  logic [1:0] denom;
  logic event_q, event_d, reject_q, reject_d, short_q, short_d;
  // value of the inserted coin, the widened sum, and the largest coin that fits in the credit
  always_comb begin
    coin_val = coin_type == 2'b11 ? C100 : coin_type == 2'b10 ? C25 : coin_type == 2'b01 ? C10 : C5;
    sum = {1'b0, credit_q} + {1'b0, coin_val};
    denom = credit_q >= C100 ? 2'b11 : credit_q >= C25 ? 2'b10 : credit_q >= C10 ? 2'b01 : 2'b00;
    change_val = credit_q >= C100 ? C100 : credit_q >= C25 ? C25 : credit_q >= C10 ? C10 : C5;
  end
  // state, credit and registered event pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ACCUM;
      credit_q <= '0;
      event_q <= 1'b0;
      reject_q <= 1'b0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      credit_q <= credit_d;
      event_q <= event_d;
      reject_q <= reject_d;
      short_q <= short_d;
    end
  end
  // next state: vend beats cancel beats coin in ACCUM; CHANGE drains credit one coin per handshake
  always_comb begin
    state_d = state_q;
    credit_d = credit_q;
    event_d = 1'b0;
    reject_d = 1'b0;
    short_d = 1'b0;
    if (state_q == ACCUM) begin
      reject_d = coin_valid && (vend_done || cancel || sum > MAX_C);
      if (vend_done) begin
        if (credit_q >= price) begin
          credit_d = credit_q - price;
          state_d = credit_q != price ? CHANGE : ACCUM;
        end
      end else if (cancel) begin
        state_d = credit_q != '0 ? CHANGE : ACCUM;
      end else if (coin_valid && sum <= MAX_C) begin
        credit_d = sum[CREDIT_W-1:0];
        event_d = 1'b1;
      end
    end else begin
      reject_d = coin_valid;
      if (credit_q < C5) begin
        credit_d = '0;
        short_d = credit_q != '0;
        state_d = ACCUM;
      end else if (change_ready) begin
        credit_d = credit_q - change_val;
        state_d = credit_q == change_val ? ACCUM : CHANGE;
      end
    end
  end
  // outputs: a coin is only presented while at least 5 cents remain
  always_comb begin
    busy = state_q == CHANGE;
    change_valid = busy && credit_q >= C5;
    change_coin = change_valid ? denom : 2'b00;
    credit_ok = !busy && price != '0 && credit_q >= price;
    credit = credit_q;
    coin_event = event_q;
    coin_reject = reject_q;
    change_short = short_q;
  end
endmodule

// File: tb/tb_coin_credit_unit.sv
// tb_coin_credit_unit: table vectors, hand-written corners and random stimulus against a coin-list model
module tb_coin_credit_unit;
  logic clk = 1'b0;
  logic reset, coin_valid, vend_done, cancel, change_ready;
  logic [1:0] coin_type;
  logic [9:0] price;
  logic [9:0] credit;
  logic credit_ok, coin_event, coin_reject, change_valid, change_short, busy;
  logic [1:0] change_coin;
  int checks = 0;
  int errors = 0;
  int m_cr = 0;
  bit m_busy = 0;
  int m_res = 0;
  int m_q[$];
  typedef struct {
    int cv, ct, vd, cn, rdy, pr;
    int cr, bz, ev, rj, vl, cc, sh, ok;
  } vec_t;
  vec_t tbl[$];

  coin_credit_unit #(.CREDIT_W(10), .MAX_CREDIT(500)) dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_type(coin_type),
    .price(price), .vend_done(vend_done), .cancel(cancel), .change_ready(change_ready),
    .credit(credit), .credit_ok(credit_ok), .coin_event(coin_event), .coin_reject(coin_reject),
    .change_valid(change_valid), .change_coin(change_coin), .change_short(change_short), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  function automatic int enc(int v);
    return v == 100 ? 3 : v == 25 ? 2 : v == 10 ? 1 : 0;
  endfunction

  // the change owed is planned as a greedy list of coins; anything under 5 is forfeited at the end
  function automatic void enter_change();
    int a;
    int d[4] = '{100, 25, 10, 5};
    a = m_cr;
    m_busy = 1;
    m_res = a % 5;
    m_q.delete();
    while (a >= 5)
      for (int i = 0; i < 4; i++)
        if (d[i] <= a) begin
          m_q.push_back(d[i]);
          a -= d[i];
          break;
        end
  endfunction

  function automatic void add(int cv, int ct, int vd, int cn, int rdy, int pr,
                              int cr, int bz, int ev, int rj, int vl, int cc, int sh, int ok);
    vec_t t;
    t = '{cv, ct, vd, cn, rdy, pr, cr, bz, ev, rj, vl, cc, sh, ok};
    tbl.push_back(t);
  endfunction

  task automatic cycle(int cv, int ct, int vd, int cn, int rdy);
    int vals[4] = '{5, 10, 25, 100};
    int v;
    bit ev, rj, sh, has;
    coin_valid = cv != 0;
    coin_type = ct[1:0];
    vend_done = vd != 0;
    cancel = cn != 0;
    change_ready = rdy != 0;
    v = vals[ct & 3];
    ev = 0;
    rj = 0;
    sh = 0;
    if (!m_busy) begin
      if (vd != 0) begin
        rj = cv != 0;
        if (m_cr >= int'(price)) begin
          m_cr -= int'(price);
          if (m_cr != 0) enter_change();
        end
      end else if (cn != 0) begin
        rj = cv != 0;
        if (m_cr != 0) enter_change();
      end else if (cv != 0) begin
        if (m_cr + v <= 500) begin
          m_cr += v;
          ev = 1;
        end else rj = 1;
      end
    end else begin
      rj = cv != 0;
      if (m_q.size() == 0) begin
        m_cr = 0;
        sh = 1;
        m_busy = 0;
      end else if (rdy != 0) begin
        m_cr -= m_q.pop_front();
        if (m_q.size() == 0 && m_res == 0) m_busy = 0;
      end
    end
    @(posedge clk);
    #1;
    has = m_busy && m_q.size() > 0;
    chk("credit", int'(credit), m_cr);
    chk("busy", int'(busy), int'(m_busy));
    chk("coin_event", int'(coin_event), int'(ev));
    chk("coin_reject", int'(coin_reject), int'(rj));
    chk("change_short", int'(change_short), int'(sh));
    chk("change_valid", int'(change_valid), int'(has));
    chk("change_coin", int'(change_coin), has ? enc(m_q[0]) : 0);
    chk("credit_ok", int'(credit_ok), int'(!m_busy && price != 0 && m_cr >= int'(price)));
  endtask

  initial begin
    reset = 1'b1;
    coin_valid = 0; coin_type = 0; vend_done = 0; cancel = 0; change_ready = 0; price = 0;
    @(posedge clk);
    #1;
    chk("rst_credit", int'(credit), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(change_valid), 0);
    chk("rst_coin", int'(change_coin), 0);
    reset = 1'b0;
    //  cv ct vd cn rdy pr  | cr bz ev rj vl cc sh ok
    add(0, 0, 0, 0, 0, 75,   0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 2, 0, 0, 0, 75,  25, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 75,  25, 0, 0, 0, 0, 0, 0, 0);
    add(1, 2, 0, 0, 0, 75,  50, 0, 1, 0, 0, 0, 0, 0);
    add(1, 2, 0, 0, 0, 75,  75, 0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 75,   0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 3, 0, 0, 0, 75, 100, 0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 75,  25, 1, 0, 0, 1, 2, 0, 0);
    add(0, 0, 0, 0, 1, 75,   0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 2, 0, 0, 0, 75,  25, 0, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 75,  35, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 75,  40, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 75,  40, 1, 0, 0, 1, 2, 0, 0);
    add(1, 3, 0, 0, 0, 75,  40, 1, 0, 1, 1, 2, 0, 0);
    add(0, 0, 1, 0, 0, 75,  40, 1, 0, 0, 1, 2, 0, 0);
    add(0, 0, 0, 1, 0, 75,  40, 1, 0, 0, 1, 2, 0, 0);
    add(0, 0, 0, 0, 1, 75,  15, 1, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1, 75,   5, 1, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 75,   0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 3, 0, 0, 0,  0, 100, 0, 1, 0, 0, 0, 0, 0);
    add(1, 3, 0, 0, 0,  0, 200, 0, 1, 0, 0, 0, 0, 0);
    add(1, 3, 0, 0, 0,  0, 300, 0, 1, 0, 0, 0, 0, 0);
    add(1, 3, 0, 0, 0,  0, 400, 0, 1, 0, 0, 0, 0, 0);
    add(1, 2, 0, 0, 0,  0, 425, 0, 1, 0, 0, 0, 0, 0);
    add(1, 2, 0, 0, 0,  0, 450, 0, 1, 0, 0, 0, 0, 0);
    add(1, 3, 0, 0, 0,  0, 450, 0, 0, 1, 0, 0, 0, 0);
    add(1, 2, 0, 0, 0,  0, 475, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0,  0, 475, 1, 0, 0, 1, 3, 0, 0);
    add(0, 0, 0, 0, 1,  0, 375, 1, 0, 0, 1, 3, 0, 0);
    add(0, 0, 0, 0, 1,  0, 275, 1, 0, 0, 1, 3, 0, 0);
    add(0, 0, 0, 0, 1,  0, 175, 1, 0, 0, 1, 3, 0, 0);
    add(0, 0, 0, 0, 1,  0,  75, 1, 0, 0, 1, 2, 0, 0);
    add(0, 0, 0, 0, 1,  0,  50, 1, 0, 0, 1, 2, 0, 0);
    add(0, 0, 0, 0, 1,  0,  25, 1, 0, 0, 1, 2, 0, 0);
    add(0, 0, 0, 0, 1,  0,   0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 2, 0, 0, 0, 73,  25, 0, 1, 0, 0, 0, 0, 0);
    add(1, 2, 0, 0, 0, 73,  50, 0, 1, 0, 0, 0, 0, 0);
    add(1, 2, 0, 0, 0, 73,  75, 0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 73,   2, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 73,   0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 73,   0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 3, 0, 0, 0, 25, 100, 0, 1, 0, 0, 0, 0, 1);
    add(1, 0, 1, 0, 0, 25,  75, 1, 0, 1, 1, 2, 0, 0);
    add(0, 0, 0, 0, 1, 25,  50, 1, 0, 0, 1, 2, 0, 0);
    add(0, 0, 0, 0, 1, 25,  25, 1, 0, 0, 1, 2, 0, 0);
    add(0, 0, 0, 0, 1, 25,   0, 0, 0, 0, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      price = 10'(tbl[i].pr);
      cycle(tbl[i].cv, tbl[i].ct, tbl[i].vd, tbl[i].cn, tbl[i].rdy);
      chk($sformatf("tbl%0d_credit", i), int'(credit), tbl[i].cr);
      chk($sformatf("tbl%0d_busy", i), int'(busy), tbl[i].bz);
      chk($sformatf("tbl%0d_event", i), int'(coin_event), tbl[i].ev);
      chk($sformatf("tbl%0d_reject", i), int'(coin_reject), tbl[i].rj);
      chk($sformatf("tbl%0d_valid", i), int'(change_valid), tbl[i].vl);
      chk($sformatf("tbl%0d_coin", i), int'(change_coin), tbl[i].cc);
      chk($sformatf("tbl%0d_short", i), int'(change_short), tbl[i].sh);
      chk($sformatf("tbl%0d_ok", i), int'(credit_ok), tbl[i].ok);
    end
    // asynchronous reset in the middle of dispensing 50
    price = 0;
    cycle(1, 2, 0, 0, 0);
    cycle(1, 2, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    chk("pre_rst_valid", int'(change_valid), 1);
    #3;
    reset = 1'b1;
    #1;
    chk("async_credit", int'(credit), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_valid", int'(change_valid), 0);
    chk("async_coin", int'(change_coin), 0);
    chk("async_ok", int'(credit_ok), 0);
    chk("async_pulses", int'({coin_event, coin_reject, change_short}), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_cr = 0;
    m_busy = 0;
    m_q.delete();
    cycle(0, 0, 0, 0, 1);
    for (int n = 0; n < 3000; n++) begin
      if (!m_busy && m_cr == 0 && $urandom_range(0, 7) == 0) price = 10'($urandom_range(0, 300));
      cycle(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 9) == 0),
            int'($urandom_range(0, 15) == 0), int'($urandom_range(0, 1)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
